// File: rtl/exec_pkg.sv
// exec_pkg: shared types and constants for the RV64 execute stage.
//   - aluOp_t    : 5-bit ALU / mul-div operation codes
//   - FWD_*      : operand forwarding selects
//   - BR_*       : branch funct3 conditions
//   - mdState_t  : mul/div FSM state encoding
//   - XLEN_DEF   : default datapath width
package exec_pkg;

    localparam int XLEN_DEF = 64;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } aluOp_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } mdState_t;

    function automatic logic isMulDiv(input aluOp_t op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                          ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/execute_stage_muldiv.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider, one bit
// per cycle over MD_ITERS cycles. Signed ops run on magnitudes; the sign is
// fixed up combinationally while the FSM sits in DONE.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         a mul/div op is present in EX
//   abort         kill the op in flight (EX flush)
//   wordOp        32-bit (*W) form: truncate operands, sign-extend result
//   op, a, b      operation and operands
//   busy          stall request (first cycle combinational from start)
//   done          result valid this cycle
//   result        final result
module muldiv_unit
    import exec_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int MD_ITERS = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            wordOp,
    input  aluOp_t          op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = (MD_ITERS > 1) ? $clog2(MD_ITERS) : 1;

    mdState_t state, stateNext;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] hi, lo, mcand, dividend;
    logic            isDiv, isRem, wantHi, negRes, negRem, divZero, wordR;

    // Operand preparation
    logic            signedA, signedB, aNeg, bNeg;
    logic [XLEN-1:0] opA, opB, magA, magB;

    assign signedA = op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    assign signedB = op inside {ALU_MULH, ALU_DIV, ALU_REM};
    assign opA = !wordOp ? a : signedA ? {{(XLEN-32){a[31]}}, a[31:0]}
                                       : {{(XLEN-32){1'b0}}, a[31:0]};
    assign opB = !wordOp ? b : signedB ? {{(XLEN-32){b[31]}}, b[31:0]}
                                       : {{(XLEN-32){1'b0}}, b[31:0]};
    assign aNeg = signedA & opA[XLEN-1];
    assign bNeg = signedB & opB[XLEN-1];
    assign magA = aNeg ? -opA : opA;
    assign magB = bNeg ? -opB : opB;

    // One iteration step: hi accumulates / holds the partial remainder,
    // lo holds the multiplier (shifting out) or dividend -> quotient.
    logic [XLEN:0]   mulSum, divShift;
    logic [XLEN-1:0] divDiff, divHi;
    logic            geq, unusedDiffMsb;

    assign mulSum   = {1'b0, hi} + {1'b0, (lo[0] ? mcand : '0)};
    assign divShift = {hi, lo[XLEN-1]};
    assign geq      = divShift >= {1'b0, mcand};
    assign {unusedDiffMsb, divDiff} = divShift - {1'b0, mcand};
    assign divHi    = geq ? divDiff : divShift[XLEN-1:0];

    // FSM
    always_ff @(posedge clk) begin
        if (rst) state <= MD_IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            MD_IDLE: begin
                busy = start & ~abort;
                if (start && !abort) stateNext = MD_BUSY;
            end
            MD_BUSY: begin
                busy = ~abort;
                if (abort)            stateNext = MD_IDLE;
                else if (count == '0) stateNext = MD_DONE;
            end
            MD_DONE: begin
                done      = ~abort;
                stateNext = MD_IDLE;
            end
            default: stateNext = MD_IDLE;
        endcase
        if (rst) busy = 1'b0;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (state == MD_IDLE) begin
            if (start) begin
                hi       <= '0;
                lo       <= magA;
                mcand    <= magB;
                dividend <= opA;
                count    <= CW'(MD_ITERS - 1);
                isDiv    <= op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
                isRem    <= op inside {ALU_REM, ALU_REMU};
                wantHi   <= op inside {ALU_MULH, ALU_MULHSU, ALU_MULHU};
                negRes   <= aNeg ^ bNeg;
                negRem   <= aNeg;
                divZero  <= (opB == '0);
                wordR    <= wordOp;
            end
        end else if (state == MD_BUSY) begin
            count <= count - CW'(1);
            if (isDiv) begin
                hi <= divHi;
                lo <= {lo[XLEN-2:0], geq};
            end else begin
                hi <= mulSum[XLEN:1];
                lo <= {mulSum[0], lo[XLEN-1:1]};
            end
        end
    end

    // Sign correction and result select
    logic [2*XLEN-1:0] prod, prodFix;
    logic [XLEN-1:0]   quot, rem, mulR, divR, raw;

    assign prod    = {hi, lo};
    assign prodFix = negRes ? -prod : prod;
    assign mulR    = wantHi ? prodFix[2*XLEN-1:XLEN] : prodFix[XLEN-1:0];
    assign quot    = negRes ? -lo : lo;
    assign rem     = negRem ? -hi : hi;
    assign divR    = divZero ? (isRem ? dividend : '1) : (isRem ? rem : quot);
    assign raw     = isDiv ? divR : mulR;
    assign result  = wordR ? {{(XLEN-32){raw[31]}}, raw[31:0]} : raw;

endmodule

// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage RV64 pipeline. Forwarding muxes,
// single-cycle ALU, branch/jump resolution, iterative mul/div (stalls the
// front end via StallE) and the EX/MEM pipeline register (*M outputs).
// Build option: define WORD_OPS_EN to honour WordOpE (RV64 *W forms);
// otherwise WordOpE is ignored.
// Ports: clk/rst (sync, active high), FlushE, decoded E controls, operands,
// ForwardAE/BE + ResultW, StallE, PCSrcE, BranchTargetE, registered *M.
module execute_stage
    import exec_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int MD_ITERS = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            FlushE,
    input  logic            RegWriteEnE,
    input  logic            MemtoRegE,
    input  logic            JALE,
    input  logic            JalrE,
    input  logic            BranchE,
    input  logic            MemReadEnE,
    input  logic            MemWriteEnE,
    input  logic            ALUSrcE,
    input  logic            WordOpE,
    input  logic [1:0]      MemSizeE,
    input  logic [1:0]      LoadSizeE,
    input  logic [2:0]      BranchTypeE,
    input  logic [4:0]      ALUOpE,
    input  logic [4:0]      RdE,
    input  logic [XLEN-1:0] PcE,
    input  logic [XLEN-1:0] PcPlus4E,
    input  logic [XLEN-1:0] ReadData1E,
    input  logic [XLEN-1:0] ReadData2E,
    input  logic [XLEN-1:0] ImmE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            StallE,
    output logic            PCSrcE,
    output logic [XLEN-1:0] BranchTargetE,
    output logic            RegWriteEnM,
    output logic            MemtoRegM,
    output logic            JALM,
    output logic            MemReadEnM,
    output logic            MemWriteEnM,
    output logic [1:0]      MemSizeM,
    output logic [1:0]      LoadSizeM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] PcPlus4M,
    output logic [XLEN-1:0] ReadData2M,
    output logic [XLEN-1:0] ALUResultM
);
    aluOp_t aluOp;
    logic   wordMode;

    assign aluOp = aluOp_t'(ALUOpE);

`ifdef WORD_OPS_EN
    assign wordMode = WordOpE;
`else
    logic unusedWordOp;
    assign wordMode     = 1'b0;
    assign unusedWordOp = WordOpE;
`endif

    // Forwarding
    logic [XLEN-1:0] fwdA, fwdB, srcB;

    always_comb begin
        case (ForwardAE)
            FWD_W:   fwdA = ResultW;
            FWD_M:   fwdA = ALUResultM;
            default: fwdA = ReadData1E;
        endcase
        case (ForwardBE)
            FWD_W:   fwdB = ResultW;
            FWD_M:   fwdB = ALUResultM;
            default: fwdB = ReadData2E;
        endcase
    end

    assign srcB = ALUSrcE ? ImmE : fwdB;

    // ALU. Word forms zero-extend A (sign-extend for SRAW so the arithmetic
    // shift pulls in bit 31), then sign-extend the low 32 result bits.
    logic [XLEN-1:0] aluA, aluRaw, aluRes;
    logic [5:0]      shamt;

    assign aluA  = !wordMode ? fwdA
                 : (aluOp == ALU_SRA) ? {{(XLEN-32){fwdA[31]}}, fwdA[31:0]}
                                      : {{(XLEN-32){1'b0}}, fwdA[31:0]};
    assign shamt = wordMode ? {1'b0, srcB[4:0]} : srcB[5:0];

    always_comb begin
        aluRaw = '0;
        case (aluOp)
            ALU_ADD:   aluRaw = aluA + srcB;
            ALU_SUB:   aluRaw = aluA - srcB;
            ALU_AND:   aluRaw = aluA & srcB;
            ALU_OR:    aluRaw = aluA | srcB;
            ALU_XOR:   aluRaw = aluA ^ srcB;
            ALU_SLL:   aluRaw = aluA << shamt;
            ALU_SRL:   aluRaw = aluA >> shamt;
            ALU_SRA:   aluRaw = XLEN'($signed(aluA) >>> shamt);
            ALU_SLT:   aluRaw = {{(XLEN-1){1'b0}}, $signed(aluA) < $signed(srcB)};
            ALU_SLTU:  aluRaw = {{(XLEN-1){1'b0}}, aluA < srcB};
            ALU_PASSB: aluRaw = srcB;
            default:   aluRaw = '0;
        endcase
    end

    assign aluRes = wordMode ? {{(XLEN-32){aluRaw[31]}}, aluRaw[31:0]} : aluRaw;

    // Branch / jump resolution (compares forwarded rs1 and rs2)
    logic cond;

    always_comb begin
        case (BranchTypeE)
            BR_EQ:   cond = (fwdA == fwdB);
            BR_NE:   cond = (fwdA != fwdB);
            BR_LT:   cond = ($signed(fwdA) <  $signed(fwdB));
            BR_GE:   cond = ($signed(fwdA) >= $signed(fwdB));
            BR_LTU:  cond = (fwdA <  fwdB);
            BR_GEU:  cond = (fwdA >= fwdB);
            default: cond = 1'b0;
        endcase
    end

    assign PCSrcE        = ~FlushE & (JALE | JalrE | (BranchE & cond));
    assign BranchTargetE = JalrE ? ((fwdA + ImmE) & ~XLEN'(1)) : (PcE + ImmE);

    // Mul/div
    logic            mdBusy, mdDone;
    logic [XLEN-1:0] mdResult;

    muldiv_unit #(.XLEN(XLEN), .MD_ITERS(MD_ITERS)) uMulDiv (
        .clk    (clk),
        .rst    (rst),
        .start  (isMulDiv(aluOp)),
        .abort  (FlushE),
        .wordOp (wordMode),
        .op     (aluOp),
        .a      (fwdA),
        .b      (srcB),
        .busy   (mdBusy),
        .done   (mdDone),
        .result (mdResult)
    );

    assign StallE = mdBusy;

    // EX/MEM register
    always_ff @(posedge clk) begin
        if (rst || FlushE || StallE) begin
            RegWriteEnM <= 1'b0;
            MemtoRegM   <= 1'b0;
            JALM        <= 1'b0;
            MemReadEnM  <= 1'b0;
            MemWriteEnM <= 1'b0;
            MemSizeM    <= '0;
            LoadSizeM   <= '0;
            RdM         <= '0;
            PcPlus4M    <= '0;
            ReadData2M  <= '0;
            ALUResultM  <= '0;
        end else begin
            RegWriteEnM <= RegWriteEnE;
            MemtoRegM   <= MemtoRegE;
            JALM        <= JALE;
            MemReadEnM  <= MemReadEnE;
            MemWriteEnM <= MemWriteEnE;
            MemSizeM    <= MemSizeE;
            LoadSizeM   <= LoadSizeE;
            RdM         <= RdE;
            PcPlus4M    <= PcPlus4E;
            ReadData2M  <= fwdB;
            ALUResultM  <= mdDone ? mdResult : aluRes;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst, FlushE;
    logic        RegWriteEnE, MemtoRegE, JALE, JalrE, BranchE;
    logic        MemReadEnE, MemWriteEnE, ALUSrcE, WordOpE;
    logic [1:0]  MemSizeE, LoadSizeE, ForwardAE, ForwardBE;
    logic [2:0]  BranchTypeE;
    logic [4:0]  ALUOpE, RdE;
    logic [63:0] PcE, PcPlus4E, ReadData1E, ReadData2E, ImmE, ResultW;
    logic        StallE, PCSrcE;
    logic [63:0] BranchTargetE;
    logic        RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM;
    logic [1:0]  MemSizeM, LoadSizeM;
    logic [4:0]  RdM;
    logic [63:0] PcPlus4M, ReadData2M, ALUResultM;

    execute_stage dut (
        .clk(clk), .rst(rst), .FlushE(FlushE),
        .RegWriteEnE(RegWriteEnE), .MemtoRegE(MemtoRegE), .JALE(JALE), .JalrE(JalrE),
        .BranchE(BranchE), .MemReadEnE(MemReadEnE), .MemWriteEnE(MemWriteEnE),
        .ALUSrcE(ALUSrcE), .WordOpE(WordOpE), .MemSizeE(MemSizeE), .LoadSizeE(LoadSizeE),
        .BranchTypeE(BranchTypeE), .ALUOpE(ALUOpE), .RdE(RdE), .PcE(PcE),
        .PcPlus4E(PcPlus4E), .ReadData1E(ReadData1E), .ReadData2E(ReadData2E),
        .ImmE(ImmE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .StallE(StallE), .PCSrcE(PCSrcE), .BranchTargetE(BranchTargetE),
        .RegWriteEnM(RegWriteEnM), .MemtoRegM(MemtoRegM), .JALM(JALM),
        .MemReadEnM(MemReadEnM), .MemWriteEnM(MemWriteEnM), .MemSizeM(MemSizeM),
        .LoadSizeM(LoadSizeM), .RdM(RdM), .PcPlus4M(PcPlus4M),
        .ReadData2M(ReadData2M), .ALUResultM(ALUResultM)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        aluOp_t      op;
        logic [1:0]  fa;
        logic [63:0] a, b, imm, resW;
        logic        aluSrc, word;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [15];

`ifdef WORD_OPS_EN
    localparam logic [63:0] EXP_ADDW = 64'hFFFF_FFFF_8000_0000;
    localparam logic [63:0] EXP_SRAW = 64'hFFFF_FFFF_F800_0000;
    localparam logic [63:0] EXP_MULW = 64'h0;
`else
    localparam logic [63:0] EXP_ADDW = 64'h0000_0000_8000_0000;
    localparam logic [63:0] EXP_SRAW = 64'h0000_0000_0800_0000;
    localparam logic [63:0] EXP_MULW = 64'h0000_0001_0000_0000;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic clearIn();
        FlushE = 0; RegWriteEnE = 0; MemtoRegE = 0; JALE = 0; JalrE = 0; BranchE = 0;
        MemReadEnE = 0; MemWriteEnE = 0; ALUSrcE = 0; WordOpE = 0;
        MemSizeE = 0; LoadSizeE = 0; ForwardAE = FWD_RF; ForwardBE = FWD_RF;
        BranchTypeE = 0; ALUOpE = ALU_ADD; RdE = 0; PcE = 0; PcPlus4E = 0;
        ReadData1E = 0; ReadData2E = 0; ImmE = 0; ResultW = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a mul/div op, count stall cycles, check M bubbles and result.
    task automatic runMd(input string name, input aluOp_t op, input logic word,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
        int  n = 0;
        logic bubbleBad = 0;
        clearIn();
        ALUOpE = op; WordOpE = word; ReadData1E = a; ReadData2E = b;
        RegWriteEnE = 1; RdE = 5'd7;
        #1;
        while (StallE === 1'b1 && n < 200) begin
            n++;
            tick();
            if (ALUResultM !== 0 || RegWriteEnM !== 0 || RdM !== 0) bubbleBad = 1;
        end
        chk({name, "_stallcycles"}, 64'(n), 64'd65);
        chk({name, "_bubble"}, 64'(bubbleBad), 64'd0);
        tick();
        chk({name, "_res"}, ALUResultM, exp);
        chk({name, "_rd"}, 64'(RdM), 64'd7);
        clearIn();
    endtask

    initial begin
        vecs[0]  = '{ALU_SUB,   FWD_RF, 64'd10, 64'd3, 64'd0, 64'd0, 1'b0, 1'b0, 64'd7};
        vecs[1]  = '{ALU_AND,   FWD_RF, 64'hF0F0, 64'hFF00, 64'd0, 64'd0, 1'b0, 1'b0, 64'hF000};
        vecs[2]  = '{ALU_OR,    FWD_RF, 64'hF0, 64'h0F, 64'd0, 64'd0, 1'b0, 1'b0, 64'hFF};
        vecs[3]  = '{ALU_XOR,   FWD_RF, 64'hFF, 64'h0F, 64'd0, 64'd0, 1'b0, 1'b0, 64'hF0};
        vecs[4]  = '{ALU_SLL,   FWD_RF, 64'd1, 64'd63, 64'd0, 64'd0, 1'b0, 1'b0, 64'h8000_0000_0000_0000};
        vecs[5]  = '{ALU_SLL,   FWD_RF, 64'd1, 64'h41, 64'd0, 64'd0, 1'b0, 1'b0, 64'd2};
        vecs[6]  = '{ALU_SRL,   FWD_RF, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'd0, 1'b0, 1'b0, 64'h0800_0000_0000_0000};
        vecs[7]  = '{ALU_SRA,   FWD_RF, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'd0, 1'b0, 1'b0, 64'hF800_0000_0000_0000};
        vecs[8]  = '{ALU_SLT,   FWD_RF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 1'b0, 1'b0, 64'd1};
        vecs[9]  = '{ALU_SLTU,  FWD_RF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0};
        vecs[10] = '{ALU_PASSB, FWD_RF, 64'd0, 64'h55, 64'h1234_5000, 64'd0, 1'b1, 1'b0, 64'h1234_5000};
        vecs[11] = '{ALU_ADD,   FWD_RF, 64'd100, 64'h66, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd99};
        vecs[12] = '{ALU_ADD,   FWD_W,  64'hBAD, 64'd1, 64'd0, 64'h1000, 1'b0, 1'b0, 64'h1001};
        vecs[13] = '{ALU_ADD,   FWD_RF, 64'h7FFF_FFFF, 64'd1, 64'd0, 64'd0, 1'b0, 1'b1, EXP_ADDW};
        vecs[14] = '{ALU_SRA,   FWD_RF, 64'h8000_0000, 64'd4, 64'd0, 64'd0, 1'b0, 1'b1, EXP_SRAW};

        // Reset with live-looking inputs: every M output must be zero
        clearIn();
        rst = 1;
        RegWriteEnE = 1; RdE = 5'd3; ReadData1E = 64'd9; PcPlus4E = 64'h44;
        tick(); tick();
        chk("rst_zero", 64'(|{RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM,
                              MemSizeM, LoadSizeM, RdM, PcPlus4M, ReadData2M, ALUResultM}), 64'd0);
        chk("rst_stall", 64'(StallE), 64'd0);
        rst = 0;

        // Table-driven single-cycle ALU vectors
        for (int i = 0; i < 15; i++) begin
            clearIn();
            ALUOpE = vecs[i].op; ForwardAE = vecs[i].fa; ReadData1E = vecs[i].a;
            ReadData2E = vecs[i].b; ImmE = vecs[i].imm; ResultW = vecs[i].resW;
            ALUSrcE = vecs[i].aluSrc; WordOpE = vecs[i].word; RdE = 5'(i + 1);
            #1;
            chk($sformatf("vec%0d_stall", i), 64'(StallE), 64'd0);
            tick();
            chk($sformatf("vec%0d_res", i), ALUResultM, vecs[i].exp);
            chk($sformatf("vec%0d_rd2", i), ReadData2M, vecs[i].b);
            chk($sformatf("vec%0d_rd", i), 64'(RdM), 64'(i + 1));
        end

        // ADD with A forwarded from ALUResultM
        clearIn();
        ReadData1E = 64'd2; ReadData2E = 64'd3;
        tick();
        chk("fwdm_prev", ALUResultM, 64'd5);
        ForwardAE = FWD_M; ReadData1E = 64'hDEAD; ReadData2E = 64'd7; RdE = 5'd9;
        RegWriteEnE = 1; MemtoRegE = 1; MemReadEnE = 1; MemSizeE = 2'b11; LoadSizeE = 2'b10;
        PcPlus4E = 64'h104;
        #1;
        chk("fwdm_stall", 64'(StallE), 64'd0);
        tick();
        chk("fwdm_res", ALUResultM, 64'd12);
        chk("fwdm_ctrl", {57'd0, RegWriteEnM, MemtoRegM, MemReadEnM, MemWriteEnM, JALM, MemSizeM},
            {57'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11});
        chk("fwdm_lsz", 64'(LoadSizeM), 64'd2);
        chk("fwdm_rdm", 64'(RdM), 64'd9);
        chk("fwdm_pc4", PcPlus4M, 64'h104);

        // Flush of a simple op gives a bubble
        clearIn();
        FlushE = 1; RegWriteEnE = 1; RdE = 5'd5; ReadData1E = 64'd1;
        tick();
        chk("flush_bubble", 64'({RegWriteEnM, RdM, ALUResultM} != 0), 64'd0);

        // Branch / jump resolution (combinational)
        clearIn();
        BranchE = 1; BranchTypeE = BR_EQ; ReadData1E = 64'h10; ReadData2E = 64'h10;
        PcE = 64'h100; ImmE = 64'h20;
        #1;
        chk("beq_taken", 64'(PCSrcE), 64'd1);
        chk("beq_target", BranchTargetE, 64'h120);
        BranchTypeE = BR_NE; #1;
        chk("bne_nottaken", 64'(PCSrcE), 64'd0);
        BranchTypeE = BR_LT; ReadData1E = 64'hFFFF_FFFF_FFFF_FFFF; ReadData2E = 64'd1; #1;
        chk("blt_taken", 64'(PCSrcE), 64'd1);
        BranchTypeE = BR_LTU; #1;
        chk("bltu_nottaken", 64'(PCSrcE), 64'd0);
        BranchTypeE = 3'b010; ReadData1E = 64'd1; #1;
        chk("br_badcode", 64'(PCSrcE), 64'd0);
        BranchTypeE = BR_LT; ReadData1E = 64'hFFFF_FFFF_FFFF_FFFF; FlushE = 1; #1;
        chk("br_flushed", 64'(PCSrcE), 64'd0);
        clearIn();
        JalrE = 1; ReadData1E = 64'h203; PcE = 64'h400; #1;
        chk("jalr_taken", 64'(PCSrcE), 64'd1);
        chk("jalr_target", BranchTargetE, 64'h202);
        tick();

        // Mul/div
        runMd("mul",   ALU_MUL,   0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        runMd("mulh",  ALU_MULH,  0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF);
        runMd("mulhu", ALU_MULHU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1);
        runMd("divmin",ALU_DIV,   0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
        runMd("divu0", ALU_DIVU,  0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        runMd("rem0",  ALU_REM,   0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9);
        runMd("divneg",ALU_DIV,   0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        runMd("remneg",ALU_REM,   0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        runMd("remu",  ALU_REMU,  0, 64'd100, 64'd7, 64'd2);
        runMd("mulw",  ALU_MUL,   1, 64'h1_0000, 64'h1_0000, EXP_MULW);

        // DIV flushed at stall cycle 10: stall drops at once, no M write
        clearIn();
        ALUOpE = ALU_DIV; ReadData1E = 64'd100; ReadData2E = 64'd7; RegWriteEnE = 1; RdE = 5'd6;
        #1;
        chk("divfl_start", 64'(StallE), 64'd1);
        repeat (9) tick();
        FlushE = 1;
        #1;
        chk("divfl_stall", 64'(StallE), 64'd0);
        tick();
        chk("divfl_nowrite", 64'({RegWriteEnM, RdM, ALUResultM} != 0), 64'd0);
        clearIn();
        ReadData1E = 64'd1; ReadData2E = 64'd1; RdE = 5'd2;
        #1;
        chk("divfl_next_stall", 64'(StallE), 64'd0);
        tick();
        chk("divfl_next_res", ALUResultM, 64'd2);

        // Reset at cycle 20 of a MUL
        clearIn();
        ALUOpE = ALU_MUL; ReadData1E = 64'd3; ReadData2E = 64'd5; RegWriteEnE = 1; RdE = 5'd4;
        repeat (19) tick();
        chk("mulrst_busy", 64'(StallE), 64'd1);
        rst = 1;
        tick();
        chk("mulrst_zero", 64'(|{RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM,
                                 MemSizeM, LoadSizeM, RdM, PcPlus4M, ReadData2M, ALUResultM}), 64'd0);
        chk("mulrst_stall", 64'(StallE), 64'd0);
        clearIn();
        rst = 0;
        ReadData1E = 64'd4; ReadData2E = 64'd4; RdE = 5'd1;
        #1;
        chk("mulrst_idle", 64'(StallE), 64'd0);
        tick();
        chk("mulrst_next", ALUResultM, 64'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 5-stage RV64 pipeline, directly upstream of memory_stage.
- Performs operand forwarding, ALU ops and branch/jump resolution.
- Contains an iterative multiply/divide unit that stalls the front end while busy.
- Owns the EX/MEM pipeline register; its registered outputs drive memory_stage's *M inputs one-for-one.

Parameters:
- XLEN, 64, datapath width.
- MD_ITERS, 64, mul/div iteration cycles (one bit per cycle).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- FlushE  in  1  kill instruction in EX (branch mispredict/hazard)
- RegWriteEnE, MemtoRegE, JALE, JalrE, BranchE, MemReadEnE, MemWriteEnE, ALUSrcE, WordOpE  in  1 each  decoded controls
- MemSizeE, LoadSizeE  in  2 each  passed through
- BranchTypeE  in  3  funct3 branch condition
- ALUOpE  in  5  operation code (package enum)
- RdE  in  5  destination register
- PcE, PcPlus4E, ReadData1E, ReadData2E, ImmE  in  64 each
- ForwardAE, ForwardBE  in  2 each  00 = register file, 01 = ResultW, 10 = ALUResultM
- ResultW  in  64  writeback result
- StallE  out  1  mul/div busy; freezes IF/ID/EX
- PCSrcE  out  1  redirect fetch
- BranchTargetE  out  64  redirect address
- RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM  out  1 each  registered
- MemSizeM, LoadSizeM  out  2 each  registered
- RdM  out  5  registered
- PcPlus4M, ReadData2M, ALUResultM  out  64 each  registered

Behaviour:
- Operand A = forward-mux(ForwardAE). Operand B: if ALUSrcE then ImmE, else forward-mux(ForwardBE).
- ReadData2M captures the forwarded rs2 value, never ImmE.
- ALU ops: ADD, SUB, AND, OR, XOR, SLL/SRL/SRA (shamt = B[5:0]), SLT, SLTU, PASSB (LUI). All single-cycle.
- Branch/jump resolution:
  - Branch condition by BranchTypeE: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; other codes are never taken.
  - PCSrcE = ~FlushE & (JALE | JalrE | (BranchE & cond)).
  - BranchTargetE = JalrE ? ((A + ImmE) & ~1) : (PcE + ImmE).
  - PCSrcE and BranchTargetE are combinational.
- EX/MEM register:
  - rst: every *M output is 0.
  - FlushE or StallE: bubble (all *M outputs 0).
  - Otherwise: loads the E-stage values; ALUResultM = ALU or mul/div result.
- Mul/div FSM, three states:
  - IDLE: an op in MUL/MULH/MULHU/MULHSU/DIV/DIVU/REM/REMU with FlushE low makes StallE=1 combinationally. Operands and signs are latched and the FSM goes to BUSY with count = MD_ITERS-1.
  - BUSY: StallE=1; shift-add multiply or restoring divide, one step per cycle. When count = 0, go to DONE.
  - DONE: StallE=0, result presented, EX/MEM loads it on this edge, then return to IDLE.
  - Latency: MD_ITERS+1 cycles from first stall cycle to EX/MEM capture.
- Division special cases (same latency):
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed MIN / -1: quotient = MIN, remainder = 0.
- Signed mul/div uses magnitudes internally, with sign correction in DONE.
- FlushE while in BUSY or DONE: abort to IDLE, no result written, StallE drops the same cycle.
- rst mid-op: IDLE, StallE=0.
- StallE and FlushE in the same cycle: flush wins.

Optional Feature:
- Macro: WORD_OPS_EN.
- Defined: WordOpE selects the RV64 *W forms. Operands are truncated to 32 bits, shift amount = B[4:0], and the result is sign-extended from bit 31 (ADDW, SUBW, SLLW, SRLW, SRAW, MULW, DIVW/DIVUW/REMW/REMUW). Word mul/div still takes MD_ITERS iterations.
- Undefined: WordOpE is ignored and every op is full 64-bit.

Decomposition:
- Package exec_pkg holds:
  - ALUOp enum (5-bit codes).
  - Forward select constants.
  - Branch funct3 constants.
  - Mul/div FSM state encoding.
  - XLEN default.
- One sub-module: muldiv_unit, containing the FSM, counter and datapath, with a start/abort/done/busy interface to execute_stage.

Test Plan:
- ADD, A=5 via ForwardAE=10 (ALUResultM=5), B=7 -> next cycle ALUResultM=12, RdM and controls registered, StallE=0.
- BEQ, A=B=0x10, PcE=0x100, ImmE=0x20 -> PCSrcE=1, BranchTargetE=0x120. JALR with A=0x203, ImmE=0 -> target 0x202.
- MUL, A=-3, B=7 -> StallE high for 65 cycles; bubbles in M meanwhile; then ALUResultM=-21 (0xFFFF_FFFF_FFFF_FFEB).
- DIV, A=0x8000_0000_0000_0000, B=-1 -> quotient 0x8000_0000_0000_0000. DIVU, B=0 -> 0xFFFF_FFFF_FFFF_FFFF. REM, B=0 -> dividend.
- DIV in progress, FlushE at cycle 10 -> StallE=0 the same cycle, no M write, next op executes normally. rst at cycle 20 of a MUL -> all outputs 0, FSM IDLE.
- WORD_OPS_EN: ADDW, A=0x7FFF_FFFF, B=1 -> 0xFFFF_FFFF_8000_0000. Without the macro, same stimulus -> 0x8000_0000.
